// File: rtl/cp_pkg.sv
// cp_pkg: shared types and widths for the computer tug-of-war opponent
package cp_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, PRESS, COOL} cp_state_t;
    localparam int RND_W = 10;
    localparam int CNT_W = 8;
endpackage

// File: rtl/cp_tick_gen.sv
// cp_tick_gen: decision pacing tick, one pulse every TICK_DIV clocks while run is high
module cp_tick_gen #(
    parameter int TICK_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);
    localparam int W = $clog2(TICK_DIV);
    logic [W-1:0] cnt;
    assign tick = run && cnt == W'(TICK_DIV - 1);
    always_ff @(posedge clk) begin
        if (reset || !run) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/computer_player_ctrl.sv
// computer_player_ctrl: computer opponent that presses on tick hits against a difficulty threshold,
// followed by a fixed cooldown
module computer_player_ctrl
    import cp_pkg::*;
#(
    parameter int TICK_DIV = 16,
    parameter int COOLDOWN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [RND_W-1:0] rnd,
    input  logic [RND_W-1:0] difficulty,
    output logic             press,
    output logic             busy,
    output logic [CNT_W-1:0] press_count
);
    localparam int CW = $clog2(COOLDOWN + 1);
    cp_state_t state, state_n;
    logic [CW-1:0] cool;
    logic tick;
    cp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .reset(reset),
        .run  (enable && state != IDLE),
        .tick (tick)
    );
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = WAIT;
            WAIT:    state_n = tick && rnd < difficulty ? PRESS : WAIT;
            PRESS:   state_n = COOL;
            COOL:    state_n = cool == CW'(1) ? WAIT : COOL;
            default: state_n = IDLE;
        endcase
        if (!enable) state_n = IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cool        <= '0;
            press_count <= '0;
        end else begin
            state <= state_n;
            // parking mid-cooldown throws the remainder away
            cool <= !enable ? '0 : state == PRESS ? CW'(COOLDOWN) : state == COOL ? cool - 1'b1 : cool;
            if (state == PRESS && press_count != '1) press_count <= press_count + 1'b1;
        end
    end
    assign press = state == PRESS;
    assign busy  = state == PRESS || state == COOL;
endmodule
